// File: rtl/control_read_hazard_pkg.sv
// Shared decode constants, state encoding and scoreboard types for the
// IR1->IR2 read-stage controller.
package ctrl_pkg;

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STOP  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_BZ    = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_NAND  = 4'd8;
    localparam logic [3:0] OP_BNZ   = 4'd9;
    localparam logic [3:0] OP_NOP   = 4'd10;
    localparam logic [3:0] OP_BPZ   = 4'd13;
    localparam logic [2:0] OP3_SHIFT = 3'd3;
    localparam logic [2:0] OP3_ORI   = 3'd7;

    localparam int X_HI  = 7;
    localparam int X_LO  = 6;
    localparam int Y_HI  = 5;
    localparam int Y_LO  = 4;
    localparam int OP_HI = 3;
    localparam int OP_LO = 0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] dest;
        logic       is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, dest: 2'b00, is_load: 1'b0};

    typedef struct packed {
        logic       s1_v;
        logic [1:0] s1;
        logic       s2_v;
        logic [1:0] s2;
        sb_entry_t  dst;
        logic       is_stop;
        logic       is_ori;
    } dec_t;

    // Register sources/destination of one instruction; flags are not tracked here.
    function automatic dec_t decode(input logic [7:0] ins, input logic [1:0] ori_reg);
        dec_t       d;
        logic [1:0] x;
        logic [1:0] y;
        x = ins[X_HI:X_LO];
        y = ins[Y_HI:Y_LO];
        d = '{s1_v: 1'b0, s1: 2'b00, s2_v: 1'b0, s2: 2'b00, dst: SB_EMPTY,
              is_stop: 1'b0, is_ori: 1'b0};
        case (ins[OP_HI:OP_LO])
            OP_ADD, OP_SUB, OP_NAND: begin
                d.s1_v = 1'b1; d.s1 = x;
                d.s2_v = 1'b1; d.s2 = y;
                d.dst  = '{valid: 1'b1, dest: x, is_load: 1'b0};
            end
            OP_LOAD: begin
                d.s1_v = 1'b1; d.s1 = y;
                d.dst  = '{valid: 1'b1, dest: x, is_load: 1'b1};
            end
            OP_STORE: begin
                d.s1_v = 1'b1; d.s1 = x;
                d.s2_v = 1'b1; d.s2 = y;
            end
            OP_STOP: begin
                d.is_stop = 1'b1;
            end
            default: begin
                case (ins[2:0])
                    OP3_SHIFT: begin
                        d.s1_v = 1'b1; d.s1 = x;
                        d.dst  = '{valid: 1'b1, dest: x, is_load: 1'b0};
                    end
                    OP3_ORI: begin
                        d.s1_v   = 1'b1; d.s1 = ori_reg;
                        d.dst    = '{valid: 1'b1, dest: ori_reg, is_load: 1'b0};
                        d.is_ori = 1'b1;
                    end
                    default: begin
                        d.is_ori = 1'b0;
                    end
                endcase
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/control_read_hazard_if.sv
// IR1/IR2 handshake and status bundle between fetch, read stage and observers.
interface control_read_hazard_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic [7:0]       instr;
    logic             flush;
    logic             ir2_load;
    logic             ir2_bubble;
    logic             fetch_stall;
    logic             r1_sel;
    logic             stop;
    logic [CNT_W-1:0] stall_count;

    modport slave (
        input  instr_valid, instr, flush,
        output ir2_load, ir2_bubble, fetch_stall, r1_sel, stop, stall_count
    );

    modport master (
        output instr_valid, instr, flush,
        input  ir2_load, ir2_bubble, fetch_stall, r1_sel, stop, stall_count
    );
endinterface

// File: rtl/control_read_hazard_scoreboard.sv
// Destination scoreboard: one entry per downstream stage, compared against
// the sources of the instruction waiting in IR1.
module hazard_scoreboard
    import ctrl_pkg::*;
#(
    parameter int HAZ_DEPTH = 3,
    parameter int FWD_EN    = 0
) (
    input  logic       clock,
    input  logic       resetn,
    input  sb_entry_t  push_i,
    input  logic       s1_v_i,
    input  logic [1:0] s1_i,
    input  logic       s2_v_i,
    input  logic [1:0] s2_i,
    output logic       hazard_o,
    output logic       empty_o
);
    sb_entry_t ent_q [HAZ_DEPTH];
    sb_entry_t ent_d [HAZ_DEPTH];

    // Shift in the newest stage entry; the oldest falls off the end.
    always_comb begin
        ent_d[0] = push_i;
        for (int i = 1; i < HAZ_DEPTH; i++) begin
            ent_d[i] = ent_q[i-1];
        end
    end

    // Entry storage.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                ent_q[i] <= SB_EMPTY;
            end
        end else begin
            ent_q <= ent_d;
        end
    end

    // With forwarding only a load still in the first stage cannot be bypassed.
    always_comb begin
        hazard_o = 1'b0;
        empty_o  = 1'b1;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            empty_o  = empty_o & ~ent_q[i].valid;
            hazard_o = hazard_o
                     | (ent_q[i].valid
                        & ((s1_v_i & (ent_q[i].dest == s1_i)) | (s2_v_i & (ent_q[i].dest == s2_i)))
                        & ((FWD_EN == 0) ? 1'b1 : ((i == 0) ? ent_q[i].is_load : 1'b0)));
        end
    end
endmodule

// File: rtl/control_read_hazard.sv
// Read-stage control: decode, RAW bubble insertion, flush squash, stop drain
// and hazard stall counting.
module control_read_hazard
    import ctrl_pkg::*;
#(
    parameter int HAZ_DEPTH = 3,
    parameter int FWD_EN    = 0,
    parameter int ORI_REG   = 1,
    parameter int CNT_W     = 16
) (
    input logic                 clock,
    input logic                 resetn,
    control_read_hazard_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    dec_t             dec_s;
    sb_entry_t        push_s;
    logic             hazard_s;
    logic             empty_s;
    logic             load_s;
    logic             bubble_s;
    logic             fstall_s;
    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic             stop_q;
    logic             stop_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign dec_s  = decode(bus.instr, 2'(ORI_REG));
    assign push_s = load_s ? dec_s.dst : SB_EMPTY;

    hazard_scoreboard #(
        .HAZ_DEPTH (HAZ_DEPTH),
        .FWD_EN    (FWD_EN)
    ) u_sb (
        .clock    (clock),
        .resetn   (resetn),
        .push_i   (push_s),
        .s1_v_i   (dec_s.s1_v),
        .s1_i     (dec_s.s1),
        .s2_v_i   (dec_s.s2_v),
        .s2_i     (dec_s.s2),
        .hazard_o (hazard_s),
        .empty_o  (empty_s)
    );

    // Issue decision and next state; flush outranks both hazard and stop.
    always_comb begin
        load_s   = 1'b0;
        bubble_s = 1'b1;
        fstall_s = 1'b0;
        state_d  = state_q;
        stop_d   = stop_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (!bus.instr_valid || bus.flush) begin
                    fstall_s = 1'b0;
                end else if (hazard_s) begin
                    fstall_s = 1'b1;
                    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                end else if (dec_s.is_stop) begin
                    fstall_s = 1'b1;
                    state_d  = ST_DRAIN;
                end else begin
                    load_s   = 1'b1;
                    bubble_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                fstall_s = 1'b1;
                if (empty_s) begin
                    state_d = ST_HALT;
                    stop_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALT: begin
                fstall_s = 1'b1;
                stop_d   = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, sticky halt and stall counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RUN;
            stop_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset forces the IR2 path to nop even while the FSM sits in RUN.
    assign bus.ir2_load    = resetn & load_s;
    assign bus.ir2_bubble  = ~resetn | bubble_s;
    assign bus.fetch_stall = resetn & fstall_s;
    assign bus.r1_sel      = resetn & dec_s.is_ori;
    assign bus.stop        = stop_q;
    assign bus.stall_count = cnt_q;
endmodule

// File: tb/tb_control_read_hazard.sv
// Bench: two instances (no forwarding / forwarding with narrow counter) driven
// in lockstep and compared every cycle against a list-based reference model.
module tb_control_read_hazard;
    localparam int HD  = 3;
    localparam int CW0 = 16;
    localparam int CW1 = 3;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    control_read_hazard_if #(.CNT_W(CW0)) if0 ();
    control_read_hazard_if #(.CNT_W(CW1)) if1 ();

    control_read_hazard #(.HAZ_DEPTH(HD), .FWD_EN(0), .ORI_REG(1), .CNT_W(CW0)) dut0 (
        .clock(clock), .resetn(resetn), .bus(if0));
    control_read_hazard #(.HAZ_DEPTH(HD), .FWD_EN(1), .ORI_REG(1), .CNT_W(CW1)) dut1 (
        .clock(clock), .resetn(resetn), .bus(if1));

    int checks   = 0;
    int failures = 0;
    int cycn     = 0;

    // Reference model: per instance the destinations of the last HD issued slots.
    int m_dest [2][HD];
    bit m_val  [2][HD];
    bit m_ld   [2][HD];
    int m_st   [2];      // 0 running, 1 draining, 2 halted
    bit m_stop [2];
    int m_cnt  [2];
    int m_max  [2] = '{(1 << CW0) - 1, (1 << CW1) - 1};

    logic obs_ld [2];
    logic obs_fs [2];
    logic obs_r1 [2];
    logic obs_stop [2];
    logic [31:0] obs_cnt [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_dec(input logic [7:0] ins, output int s1, output int s2,
                                    output int d, output bit ld, output bit stp, output bit ori);
        int op, x, y, low3;
        op = int'(ins[3:0]); x = int'(ins[7:6]); y = int'(ins[5:4]); low3 = int'(ins[2:0]);
        s1 = -1; s2 = -1; d = -1; ld = 1'b0; stp = 1'b0; ori = 1'b0;
        if (op == 4 || op == 6 || op == 8) begin s1 = x; s2 = y; d = x; end
        else if (op == 0) begin s1 = y; d = x; ld = 1'b1; end
        else if (op == 2) begin s1 = x; s2 = y; end
        else if (op == 1) stp = 1'b1;
        else if (low3 == 3) begin s1 = x; d = x; end
        else if (low3 == 7) begin s1 = 1; d = 1; ori = 1'b1; end
    endfunction

    function automatic bit m_haz(input int k, input int s1, input int s2);
        bit h = 1'b0;
        for (int i = 0; i < HD; i++) begin
            if (m_val[k][i] && (m_dest[k][i] == s1 || m_dest[k][i] == s2) &&
                (k == 0 || (i == 0 && m_ld[k][i]))) h = 1'b1;
        end
        return h;
    endfunction

    task automatic check_outs(input int k, input bit el, input bit eb, input bit ef, input bit er1);
        logic ob;
        string p;
        p = $sformatf("c%0d_d%0d", cycn, k);
        if (k == 0) begin
            obs_ld[0] = if0.ir2_load; obs_fs[0] = if0.fetch_stall; obs_r1[0] = if0.r1_sel;
            obs_stop[0] = if0.stop; obs_cnt[0] = 32'(if0.stall_count); ob = if0.ir2_bubble;
        end else begin
            obs_ld[1] = if1.ir2_load; obs_fs[1] = if1.fetch_stall; obs_r1[1] = if1.r1_sel;
            obs_stop[1] = if1.stop; obs_cnt[1] = 32'(if1.stall_count); ob = if1.ir2_bubble;
        end
        chk({p, "_load"},   32'(obs_ld[k]),   32'(el));
        chk({p, "_bubble"}, 32'(ob),          32'(eb));
        chk({p, "_fstall"}, 32'(obs_fs[k]),   32'(ef));
        chk({p, "_r1sel"},  32'(obs_r1[k]),   32'(er1));
        chk({p, "_stop"},   32'(obs_stop[k]), 32'(m_stop[k]));
        chk({p, "_cnt"},    obs_cnt[k],       32'(m_cnt[k]));
    endtask

    // Called at a falling edge; asynchronous reset takes effect before the check.
    task automatic do_reset();
        resetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < HD; i++) m_val[k][i] = 1'b0;
            m_st[k] = 0; m_stop[k] = 1'b0; m_cnt[k] = 0;
        end
        #1;
        for (int k = 0; k < 2; k++) check_outs(k, 1'b0, 1'b1, 1'b0, 1'b0);
        cycn++;
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic cyc(input bit iv, input logic [7:0] ins, input bit fl);
        int s1, s2, d;
        bit ld, stp, ori, allinv;
        bit el [2];
        bit ef [2];
        bit inc [2];
        int nxt [2];
        if0.instr_valid = iv; if0.instr = ins; if0.flush = fl;
        if1.instr_valid = iv; if1.instr = ins; if1.flush = fl;
        #1;
        ref_dec(ins, s1, s2, d, ld, stp, ori);
        for (int k = 0; k < 2; k++) begin
            el[k] = 1'b0; ef[k] = 1'b0; inc[k] = 1'b0; nxt[k] = m_st[k];
            if (m_st[k] != 0) ef[k] = 1'b1;
            else if (!iv || fl) ef[k] = 1'b0;
            else if (m_haz(k, s1, s2)) begin ef[k] = 1'b1; inc[k] = 1'b1; end
            else if (stp) begin ef[k] = 1'b1; nxt[k] = 1; end
            else el[k] = 1'b1;
            check_outs(k, el[k], ~el[k], ef[k], ori);
        end
        cycn++;
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            allinv = 1'b1;
            for (int i = 0; i < HD; i++) if (m_val[k][i]) allinv = 1'b0;
            if (m_st[k] == 1 && allinv) begin m_st[k] = 2; m_stop[k] = 1'b1; end
            else if (m_st[k] == 0) m_st[k] = nxt[k];
            for (int i = HD - 1; i > 0; i--) begin
                m_val[k][i] = m_val[k][i-1]; m_dest[k][i] = m_dest[k][i-1]; m_ld[k][i] = m_ld[k][i-1];
            end
            m_val[k][0] = el[k] && (d >= 0); m_dest[k][0] = d; m_ld[k][0] = ld;
            if (inc[k] && m_cnt[k] < m_max[k]) m_cnt[k]++;
        end
        @(negedge clock);
    endtask

    initial begin
        logic [7:0] ri;
        bit riv, rfl;
        if0.instr_valid = 1'b1; if0.instr = 8'h2F; if0.flush = 1'b0;
        if1.instr_valid = 1'b1; if1.instr = 8'h2F; if1.flush = 1'b0;
        @(negedge clock);
        do_reset();
        do_reset();

        // Plain add issues at once; ori selects the implicit register and self-stalls.
        cyc(1'b1, 8'hB4, 1'b0);
        chk("t1_load", 32'(obs_ld[0]), 32'd1);
        cyc(1'b1, 8'h2F, 1'b0);
        chk("t2_r1sel", 32'(obs_r1[0]), 32'd1);
        chk("t2_load", 32'(obs_ld[0]), 32'd1);
        cyc(1'b1, 8'h2F, 1'b0);
        chk("t2_stall", 32'(obs_fs[0]), 32'd1);

        // RAW on k2 without forwarding: three stalls then issue.
        do_reset();
        cyc(1'b1, 8'hB4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h24, 1'b0);
            chk("t3_stall", 32'(obs_fs[0]), 32'd1);
        end
        cyc(1'b1, 8'h24, 1'b0);
        chk("t3_issue", 32'(obs_ld[0]), 32'd1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t3_count", obs_cnt[0], 32'd3);

        // Load-use with forwarding: one stall, then back-to-back issue.
        do_reset();
        cyc(1'b1, 8'h60, 1'b0);
        cyc(1'b1, 8'h14, 1'b0);
        chk("t4_stall", 32'(obs_fs[1]), 32'd1);
        cyc(1'b1, 8'h14, 1'b0);
        chk("t4_issue", 32'(obs_ld[1]), 32'd1);
        cyc(1'b1, 8'hB4, 1'b0);
        chk("t4_b2b", 32'(obs_ld[1]), 32'd1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t4_count", obs_cnt[1], 32'd1);

        // Stop drains the three stages, then halt sticks.
        do_reset();
        cyc(1'b1, 8'hB4, 1'b0);
        cyc(1'b1, 8'h01, 1'b0);
        chk("t5_noload", 32'(obs_ld[0]), 32'd0);
        chk("t5_fstall", 32'(obs_fs[0]), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 8'hB4, 1'b0);
            chk("t5_prestop", 32'(obs_stop[0]), 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(i[0], 8'hB4, 1'b0);
            chk("t5_stop", 32'(obs_stop[0]), 32'd1);
            chk("t5_hold", 32'(obs_fs[0]), 32'd1);
        end

        // Stop squashed by flush leaves the FSM running.
        do_reset();
        cyc(1'b1, 8'h01, 1'b1);
        chk("t6_flush_fs", 32'(obs_fs[0]), 32'd0);
        cyc(1'b1, 8'hB4, 1'b0);
        chk("t6_run", 32'(obs_ld[0]), 32'd1);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        cyc(1'b1, 8'hB4, 1'b0);
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        do_reset();
        chk("t6_rst_stop", 32'(obs_stop[0]), 32'd0);
        cyc(1'b1, 8'hB4, 1'b0);
        chk("t6_rst_issue", 32'(obs_ld[0]), 32'd1);

        // Random traffic with rare stops, flushes and resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                ri = 8'($urandom);
                if (ri[3:0] == 4'd1 && $urandom_range(0, 9) != 0) ri[3:0] = 4'd4;
                riv = ($urandom_range(0, 9) < 8);
                rfl = ($urandom_range(0, 9) == 0);
                cyc(riv, ri, rfl);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
